program_sequencer: RTL and testbench
====================================

PROGRAM_SEQUENCER -- requirements
Module: program_sequencer

Interface
REQ-001 Parameter ADDR_W, default 8: program-counter and program-address width.
REQ-002 Parameter STACK_DEPTH, default 4: return-stack entries.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst_n  input  1  reset; asynchronous and active-low.
REQ-005 halt  input  1  high freezes PC and stack.
REQ-006 prog_data  input  4+ADDR_W  program word from combinational program memory; [ADDR_W+3:ADDR_W] opcode, [ADDR_W-1:0] operand address.
REQ-007 jmp  input  1  ICU jump flag.
REQ-008 rtn  input  1  ICU return flag.
REQ-009 flag_f  input  1  ICU NOPF flag, used as subroutine call.
REQ-010 prog_addr  output  ADDR_W  current PC, drives program memory.
REQ-011 instruction  output  instruction_t  opcode field of prog_data, combinational, fed to the ICU.
REQ-012 depth  output  clog2(STACK_DEPTH+1)  stack occupancy.
REQ-013 stack_err  output  1  sticky overflow/underflow indicator.

Function
REQ-014 Sequencer SHALL execute one program word per clk cycle; ICU latches instruction on the following negedge, and its flags are sampled on the next posedge.
REQ-015 At each posedge, with halt low, next PC SHALL be chosen by priority: rtn -> pop; jmp -> operand; flag_f -> push PC, then PC <- operand; otherwise PC+1.
REQ-016 Jump and call targets SHALL be the operand field of prog_data present at that posedge (word at current PC); no delay slot.
REQ-017 Call SHALL push the current PC (the call word's own address), not PC+1; after return, the ICU's post-RTN skip discards the re-fetched call word.
REQ-018 Increment SHALL wrap modulo 2^ADDR_W (e.g. 8'hFF -> 8'h00) with no flag.
REQ-019 Push with depth == STACK_DEPTH SHALL still jump, SHALL discard the push, and SHALL set stack_err.
REQ-020 Pop with depth == 0 SHALL load PC <- 0 and SHALL set stack_err.
REQ-021 halt high SHALL hold PC, stack and depth unchanged regardless of flags; instruction output continues to follow prog_data.
REQ-022 stack_err SHALL remain set until reset.

Reset
REQ-023 rst_n low SHALL immediately force PC = 0, depth = 0, stack_err = 0; stack contents are don't-care.
REQ-024 Reset asserted mid-call or mid-return SHALL abandon the operation; first posedge after release SHALL fetch address 0 -> 1 normally.

Configuration
REQ-025 Macro RETURN_STACK_EN: when defined, the return stack and REQ-015 call/return behaviour are built.
REQ-026 Without RETURN_STACK_EN: flag_f and rtn SHALL be ignored (PC+1), depth SHALL be tied to 0, stack_err SHALL be tied to 0, and no stack storage is built.

Structure
REQ-027 ADDR_W, STACK_DEPTH defaults and the prog_data field positions SHALL live in the shared instructions package alongside instruction_t.
REQ-028 LIFO storage SHALL be a sub-module return_stack (push, pop, data in/out, depth, full, empty), instantiated only under RETURN_STACK_EN.

Verification
REQ-029 Reset release, no flags, 260 cycles -> prog_addr 0,1,...,255,0,1,2,3; stack_err 0.
REQ-030 At PC 8'h10, jmp with operand 8'h40 -> next prog_addr 8'h40, depth unchanged.
REQ-031 At PC 8'h05, flag_f with operand 8'h80; later rtn at 8'h83 -> PC 8'h80, depth 1, then PC 8'h05, depth 0.
REQ-032 Five nested calls, STACK_DEPTH 4 -> fifth call jumps, depth stays 4, stack_err 1; then rtn at depth 0 -> PC 0, stack_err still 1.
REQ-033 jmp and rtn together at depth 1 (top 8'h22) -> PC 8'h22; halt high 3 cycles with jmp -> PC frozen.
REQ-034 rst_n pulsed low mid-cycle at depth 2 -> PC, depth, stack_err 0 asynchronously, before next edge.

Source files
------------

// File: rtl/program_sequencer_pkg.sv
// Shared instruction-word definitions for the program sequencer and its ICU.
// Holds the default address/stack sizing and the prog_data field layout.
// Feature macro used by the sequencer: RETURN_STACK_EN (call/return support).
package program_sequencer_pkg;

    // Default sizing
    localparam int DEF_ADDR_W      = 8;
    localparam int DEF_STACK_DEPTH = 4;

    // prog_data layout: {opcode[OPCODE_W-1:0], operand[ADDR_W-1:0]}
    // The operand sits at the bottom; the opcode starts right above it.
    localparam int OPCODE_W    = 4;
    localparam int OPERAND_LSB = 0;

    // Opcode field handed to the ICU
    typedef logic [OPCODE_W-1:0] instruction_t;

    // Bit position of the opcode field for a given address width
    function automatic int opcode_lsb(input int addr_w);
        return OPERAND_LSB + addr_w;
    endfunction

endpackage

// File: rtl/program_sequencer_return_stack.sv
// LIFO of return addresses for subroutine calls.
// Latency: push/pop take effect at the next posedge; dout is the current top, combinational.
// Backpressure: push while full and pop while empty are ignored; the caller flags the error.
module return_stack
    import program_sequencer_pkg::*;
#(
    parameter int  DATA_W = DEF_ADDR_W,
    parameter int  DEPTH  = DEF_STACK_DEPTH,
    localparam int CNT_W  = $clog2(DEPTH + 1),
    localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic [CNT_W-1:0]  depth,
    output logic              full,
    output logic              empty
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [IDX_W-1:0]  wr_idx, rd_idx;

    assign full   = (cnt_q == CNT_W'(DEPTH));
    assign empty  = (cnt_q == '0);
    assign depth  = cnt_q;
    assign wr_idx = IDX_W'(cnt_q);
    assign rd_idx = IDX_W'(cnt_q - CNT_W'(1));
    // Top-of-stack; forced to zero when empty so an out-of-range index is never read
    assign dout   = empty ? '0 : mem_q[rd_idx];

    // Occupancy update; overflowing pushes and underflowing pops leave it unchanged
    always_comb begin
        cnt_d = cnt_q;
        if (push && !full) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if (pop && !empty) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // Occupancy register, cleared by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Entry storage; contents after reset are don't-care, so no reset here
    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem_q[wr_idx] <= din;
        end
    end

endmodule

// File: rtl/program_sequencer.sv
// Program counter sequencer: picks the next fetch address from ICU flags (return, jump, call, increment).
// Latency: one program word per cycle; the target is taken from the word at the current PC, no delay slot.
// Backpressure: halt freezes PC and stack. Call/return are built only with RETURN_STACK_EN defined.
module program_sequencer
    import program_sequencer_pkg::*;
#(
    parameter int  ADDR_W      = DEF_ADDR_W,
    parameter int  STACK_DEPTH = DEF_STACK_DEPTH,
    localparam int DEPTH_W     = $clog2(STACK_DEPTH + 1)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       halt,
    input  logic [ADDR_W+OPCODE_W-1:0] prog_data,
    input  logic                       jmp,
    input  logic                       rtn,
    input  logic                       flag_f,
    output logic [ADDR_W-1:0]          prog_addr,
    output instruction_t               instruction,
    output logic [DEPTH_W-1:0]         depth,
    output logic                       stack_err
);

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] operand;

    assign operand     = prog_data[OPERAND_LSB +: ADDR_W];
    assign instruction = prog_data[opcode_lsb(ADDR_W) +: OPCODE_W];
    assign prog_addr   = pc_q;

`ifdef RETURN_STACK_EN
    logic               st_push, st_pop, st_full, st_empty;
    logic [ADDR_W-1:0]  st_top;
    logic [DEPTH_W-1:0] st_depth;
    logic               err_q, err_d;

    return_stack #(
        .DATA_W (ADDR_W),
        .DEPTH  (STACK_DEPTH)
    ) u_return_stack (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (st_push),
        .pop   (st_pop),
        .din   (pc_q),
        .dout  (st_top),
        .depth (st_depth),
        .full  (st_full),
        .empty (st_empty)
    );

    // Next-PC priority: return, jump, call, increment. The call pushes its own
    // address; the ICU skips the re-fetched call word after the return.
    always_comb begin
        pc_d    = pc_q;
        err_d   = err_q;
        st_push = 1'b0;
        st_pop  = 1'b0;
        if (!halt) begin
            if (rtn) begin
                if (st_empty) begin
                    pc_d  = '0;
                    err_d = 1'b1;
                end else begin
                    pc_d   = st_top;
                    st_pop = 1'b1;
                end
            end else if (jmp) begin
                pc_d = operand;
            end else if (flag_f) begin
                pc_d = operand;
                if (st_full) begin
                    err_d = 1'b1;
                end else begin
                    st_push = 1'b1;
                end
            end else begin
                pc_d = pc_q + ADDR_W'(1);
            end
        end
    end

    // Sticky stack error, cleared only by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign depth     = st_depth;
    assign stack_err = err_q;
`else
    // Call and return flags have no meaning without a return stack
    logic unused_flags;
    assign unused_flags = rtn ^ flag_f;

    // Next-PC choice without a stack: jump or wrap-around increment
    always_comb begin
        pc_d = pc_q;
        if (!halt) begin
            if (jmp) begin
                pc_d = operand;
            end else begin
                pc_d = pc_q + ADDR_W'(1);
            end
        end
    end

    assign depth     = '0;
    assign stack_err = 1'b0;
`endif

    // Program counter register; reset forces the fetch back to address 0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= '0;
        end else begin
            pc_q <= pc_d;
        end
    end

endmodule

// File: tb/tb_program_sequencer.sv
// Scoreboard bench for program_sequencer: driver issues one word per cycle and queues the
// expected post-edge state from a queue-based reference model; a monitor pops and compares.
// Directed scenarios (wrap, jump, call/return, overflow/underflow, halt, async reset) then random traffic.
module tb_program_sequencer;
    import program_sequencer_pkg::*;

    localparam int AW = 8;
    localparam int SD = 4;
    localparam int DW = $clog2(SD + 1);

    logic              clk = 1'b0;
    logic              rst_n;
    logic              halt = 1'b0;
    logic              jmp = 1'b0;
    logic              rtn = 1'b0;
    logic              flag_f = 1'b0;
    logic [AW+3:0]     prog_data = '0;
    logic [AW-1:0]     prog_addr;
    instruction_t      instruction;
    logic [DW-1:0]     depth;
    logic              stack_err;

    always #5 clk = ~clk;

    program_sequencer #(.ADDR_W(AW), .STACK_DEPTH(SD)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .halt        (halt),
        .prog_data   (prog_data),
        .jmp         (jmp),
        .rtn         (rtn),
        .flag_f      (flag_f),
        .prog_addr   (prog_addr),
        .instruction (instruction),
        .depth       (depth),
        .stack_err   (stack_err)
    );

    typedef struct {
        int pc;
        int dep;
        int err;
        int opc;
    } exp_t;

    exp_t sb_q[$];
    int   m_pc;
    int   m_stack[$];
    int   m_err;
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, req);
    endtask

    // Reference model: behavioural rules on an integer PC and a queue stack
    function automatic void model_step(input bit h, input bit j, input bit r, input bit f,
                                       input int opnd);
        if (h) return;
`ifdef RETURN_STACK_EN
        if (r) begin
            if (m_stack.size() == 0) begin
                m_pc  = 0;
                m_err = 1;
            end else begin
                m_pc = m_stack.pop_back();
            end
            return;
        end
`endif
        if (j) begin
            m_pc = opnd;
            return;
        end
`ifdef RETURN_STACK_EN
        if (f) begin
            if (m_stack.size() == SD) m_err = 1;
            else m_stack.push_back(m_pc);
            m_pc = opnd;
            return;
        end
`endif
        m_pc = (m_pc + 1) % (1 << AW);
    endfunction

    function automatic void model_reset();
        m_pc = 0;
        m_err = 0;
        m_stack.delete();
    endfunction

    // One program word per cycle; inputs change on the negedge
    task automatic step(input bit h, input bit j, input bit r, input bit f,
                        input int opnd, input int opc);
        exp_t e;
        logic [3:0]    opc_v;
        logic [AW-1:0] opnd_v;
        opc_v  = 4'(opc);
        opnd_v = AW'(opnd);
        halt = h; jmp = j; rtn = r; flag_f = f;
        prog_data = {opc_v, opnd_v};
        @(posedge clk);
        model_step(h, j, r, f, opnd);
        e.pc  = m_pc;
        e.dep = m_stack.size();
        e.err = m_err;
        e.opc = opc;
        sb_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, i % 16);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_prog_addr"}, int'(prog_addr), 0);
        check({tag, "_depth"}, int'(depth), 0);
        check({tag, "_stack_err"}, int'(stack_err), 0);
    endtask

    // Synchronous-to-bench reset: asserted at a negedge, released at the next
    task automatic do_reset();
        halt = 0; jmp = 0; rtn = 0; flag_f = 0;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_reset_state("reset");
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Monitor: compare every queued expectation just after the edge it belongs to
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            while (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check("prog_addr", int'(prog_addr), e.pc);
                check("depth", int'(depth), e.dep);
                check("stack_err", int'(stack_err), e.err);
                check("instruction", int'(instruction), e.opc);
            end
        end
    end

    // Watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b1;
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_reset_state("initial_reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Free-running fetch with wrap at 8'hFF
        idle(260);

        // Plain jump from 8'h10 to 8'h40
        step(0, 1, 0, 0, 8'h10, 2);
        step(0, 1, 0, 0, 8'h40, 3);
        idle(2);

        // Call at 8'h05 to 8'h80, return from 8'h83
        do_reset();
        step(0, 1, 0, 0, 8'h05, 1);
        step(0, 0, 0, 1, 8'h80, 7);
        idle(3);
        step(0, 0, 1, 0, 8'h00, 9);
        idle(2);

        // Five nested calls overflow a 4-deep stack, then drain past empty
        do_reset();
        idle(1);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 1, 8'h10 * (i + 1), 7);
        for (int i = 0; i < 5; i++) step(0, 0, 1, 0, 8'hEE, 9);
        idle(2);

        // jmp + rtn together at depth 1, then halt with jmp pending
        do_reset();
        step(0, 1, 0, 0, 8'h22, 1);
        step(0, 0, 0, 1, 8'h50, 7);
        step(0, 1, 1, 0, 8'h99, 4);
        for (int i = 0; i < 3; i++) step(1, 1, 0, 0, 8'hA5, 5);
        idle(2);

        // Asynchronous reset asserted mid-cycle at depth 2
        do_reset();
        step(0, 0, 0, 1, 8'h30, 7);
        step(0, 0, 0, 1, 8'h60, 7);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_reset_state("async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        idle(3);

        // Random traffic
        do_reset();
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 9) == 0, $urandom_range(0, 5) == 0,
                 $urandom_range(0, 7) == 0, $urandom_range(0, 6) == 0,
                 int'($urandom_range(0, 255)), int'($urandom_range(0, 15)));
        end
        idle(2);

        @(posedge clk);
        #2;
        if (sb_q.size() != 0) check("scoreboard_drain", sb_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
